// File: rtl/pad_reader.sv
// NES-style serial pad reader: latches the pad once per frame tick, shifts in eight
// active-low bits and publishes the decoded button vector at a single registered update.
module pad_reader #(
  parameter int unsigned HALF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       pad_data_i,
  output logic       pad_latch_o,
  output logic       pad_clk_o,
  output logic [5:0] btn_o,
  output logic [1:0] aux_o,
  output logic       btn_valid_o,
  output logic       busy_o
);

  localparam logic [8:0] LatchLast = 9'(2 * HALF - 1);
  localparam logic [8:0] PhaseLast = 9'(HALF - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StSlotLo,
    StSlotHi,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic [1:0] sync_q;
  logic [5:0] btn_q, btn_d;
  logic [1:0] aux_q, aux_d;
  logic       pad_latch_q, pad_latch_d;
  logic       pad_clk_q, pad_clk_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 9'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    btn_d   = btn_q;
    aux_d   = aux_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start_i) begin
          state_d = StLatch;
        end
      end
      StLatch: begin
        if (cnt_q == LatchLast) begin
          state_d = StSlotLo;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      StSlotLo: begin
        // Sample on the last low cycle so the synchronizer has settled after the shift.
        if (cnt_q == PhaseLast) begin
          shift_d[idx_q] = sync_q[1];
          state_d        = StSlotHi;
          cnt_d          = '0;
        end
      end
      StSlotHi: begin
        if (cnt_q == PhaseLast) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = StDone;
            // Pad bits are active-low; remap into {X, O, DOWN, UP, RIGHT, LEFT}.
            btn_d   = {~shift_q[1], ~shift_q[0], ~shift_q[5], ~shift_q[4],
                       ~shift_q[7], ~shift_q[6]};
            aux_d   = {~shift_q[3], ~shift_q[2]};
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = StSlotLo;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pad_latch_d = (state_d == StLatch);
    pad_clk_d   = (state_d != StSlotLo);
    valid_d     = (state_d == StDone);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= 8'hFF;
      sync_q      <= 2'b11;
      btn_q       <= '0;
      aux_q       <= '0;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b1;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      sync_q      <= {sync_q[0], pad_data_i};
      btn_q       <= btn_d;
      aux_q       <= aux_d;
      pad_latch_q <= pad_latch_d;
      pad_clk_q   <= pad_clk_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign pad_latch_o = pad_latch_q;
  assign pad_clk_o   = pad_clk_q;
  assign btn_o       = btn_q;
  assign aux_o       = aux_q;
  assign btn_valid_o = valid_q;
  assign busy_o      = busy_q;

endmodule

// File: doc/pad_reader.md
# pad_reader

Serial game-controller front end that produces the `btn[5:0]` vector consumed by the player physics block. Once per frame tick it latches an 8-bit NES-style shift-register pad, clocks out all eight bits, and decodes them into the active-high button vector. `btn` changes only at a single registered update point per frame, so downstream edge detection (jump/dash press) sees one clean transition per frame.

## Interface
- `HALF`, default 4: pad_clk half-period in clk cycles; legal range 4..255.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  frame tick; single-cycle pulse requesting one read.
- `pad_data`  in  1  serial data from pad, active-low (0 = pressed), asynchronous.
- `pad_latch`  out  1  latch strobe to pad, active-high.
- `pad_clk`  out  1  shift clock to pad; idles high.
- `btn`  out  6  {X, O, DOWN, UP, RIGHT, LEFT}, bit0 = LEFT; 1 = pressed.
- `aux`  out  2  {START, SELECT}; 1 = pressed.
- `btn_valid`  out  1  one-cycle pulse coincident with the `btn`/`aux` update.
- `busy`  out  1  read transaction in progress.

## Operation
- `pad_data` passes through a 2-flop synchronizer before any use.
- FSM states: IDLE, LATCH, SLOT_LO, SLOT_HI, DONE.
- IDLE: `pad_latch`=0, `pad_clk`=1, `busy`=0. On `start`=1, go to LATCH next cycle. `start` in any other state is ignored; it is not queued.
- LATCH: `pad_latch`=1 for 2*HALF cycles. Then go to SLOT_LO with bit index 0.
- SLOT_LO: `pad_clk`=0 for HALF cycles. On the last cycle of the phase, sample the synchronized data into shift bit[index].
- SLOT_HI: `pad_clk`=1 for HALF cycles. The rising edge advances the pad. At the end of the phase, if index=7 go to DONE; otherwise increment index and go to SLOT_LO.
- DONE (one cycle): register the decoded outputs, pulse `btn_valid`, then return to IDLE.
- A single phase counter is reused across states. Width is 9 bits, enough for 2*HALF; it reloads on every state change. Bit index is 3 bits and never wraps past 7.
- Pad bit order and mapping (pressed = sampled 0):
  - bit0 A → btn[4] (O); bit1 B → btn[5] (X).
  - bit2 Select → aux[0]; bit3 Start → aux[1].
  - bit4 Up → btn[2]; bit5 Down → btn[3].
  - bit6 Left → btn[0]; bit7 Right → btn[1].
- No SOCD cleaning: LEFT and RIGHT both pressed are passed through as both 1. Resolving that is the consumer's job.
- `btn`/`aux` hold their value between DONE cycles, regardless of `pad_data` activity.

## Timing
- Reset values: `pad_latch`=0, `pad_clk`=1, `btn`=0, `aux`=0, `btn_valid`=0, `busy`=0. The FSM goes to IDLE, the counters clear, and the synchronizer flops are set to 1 (released).
- Let `start` be seen in IDLE at cycle 0.
  - `pad_latch`=1 during cycles 1..2H.
  - Slot k (k=0..7) occupies cycles 2H+1+2Hk .. 2H+2H(k+1). The low phase is the first H cycles of the slot.
  - Bit k is sampled at cycle 2H+2Hk+H.
  - `btn_valid` and the new `btn` appear at cycle 18H+1. Outputs are registered and visible that cycle.
- `busy`=1 during cycles 1..18H+1 inclusive. It is 0 from cycle 18H+2, when a new `start` is accepted.
- Sampling at the end of the low phase allows 2 synchronizer cycles plus pad propagation. This is why HALF must be ≥4.
- Reset mid-transaction aborts immediately. `pad_latch` returns to 0 and `pad_clk` to 1 in the next cycle. `btn` clears to 0, with no `btn_valid` pulse. A partial shift is discarded.
- `start` held high continuously gives back-to-back reads every 18H+2 cycles.

## Test plan
- Pad model with all bits released (data=1), HALF=4, pulse `start` → `pad_latch` high for exactly 8 cycles, exactly 8 pad_clk low pulses of 4 cycles each, `btn_valid` at cycle 73, `btn`=6'b000000, `aux`=2'b00.
- Pad pressing A and Right (bits 0, 7 low) → `btn`=6'b010010 at cycle 73. Pressing all eight → `btn`=6'b111111, `aux`=2'b11.
- Pad changes pattern to Left-only while a read is in progress after bit 6 was sampled, then the next read runs → first result does not include Left. The second read gives `btn`=6'b000001. `btn` is stable between the two `btn_valid` pulses.
- `start` pulsed at cycles 0, 10, 40 → exactly one transaction; `btn_valid` at cycle 73 only. `start` at cycle 74 is accepted and gives `btn_valid` at cycle 147.
- Assert `rst` at cycle 30 of a read with the pad pressing B → next cycle `pad_latch`=0, `pad_clk`=1, `busy`=0, `btn`=0, no `btn_valid` pulse. A following `start` completes normally with `btn`=6'b100000.
- HALF=5 build, Up+Down pressed → `btn_valid` at cycle 91, `btn`=6'b001100. No sample is ever taken in a cycle where `pad_clk` is high.
